// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the F-stage PC, runs the instruction-memory req/ack handshake
// and loads the F/D register, with delay-slot redirects, stall buffering and address-error tagging.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
   parameter int unsigned IMEM_WORDS = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fd_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        fd_valid,
   output logic [31:0] fd_pc,
   output logic [31:0] fd_instr,
   output logic        fd_adel
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // One past the last legal byte address; 33 bits so a window ending at 4 GiB cannot wrap.
   localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BASE) + (33'(IMEM_WORDS) << 2);

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] hold_instr;
   logic        hold_adel;
   logic        pending_valid;
   logic [31:0] pending_pc;

   logic        pc_legal;
   logic        fetch_done;
   logic [31:0] fetch_word;
   logic        deliver;
   logic        take_redirect;
   logic [31:0] next_pc;

   assign pc_legal = (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && ({1'b0, pc} < IMEM_LIMIT);

   // An illegal PC never reaches memory; it completes at once with a zero word and the error flag.
   assign fetch_done    = (state == ST_WAIT) && (!pc_legal || imem_ack);
   assign fetch_word    = pc_legal ? imem_rdata : 32'h0;
   assign deliver       = !fd_stall && (fetch_done || (state == ST_HOLD));
   assign take_redirect = redirect_valid && !fd_stall;
   assign next_pc       = pending_valid ? pending_pc : pc + 32'd4;

   assign imem_req  = (state == ST_WAIT) && pc_legal;
   assign imem_addr = pc;

   // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         pc            <= RESET_PC;
         hold_instr    <= 32'h0;
         hold_adel     <= 1'b0;
         pending_valid <= 1'b0;
         pending_pc    <= 32'h0;
         fd_valid      <= 1'b0;
         fd_pc         <= 32'h0;
         fd_instr      <= 32'h0;
         fd_adel       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: state <= ST_WAIT;
            ST_WAIT: begin
               if (fetch_done && fd_stall) begin
                  hold_instr <= fetch_word;
                  hold_adel  <= !pc_legal;
                  state      <= ST_HOLD;
               end else if (fetch_done) begin
                  fd_valid <= 1'b1;
                  fd_pc    <= pc;
                  fd_instr <= fetch_word;
                  fd_adel  <= !pc_legal;
               end else if (!fd_stall) begin
                  fd_valid <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (!fd_stall) begin
                  fd_valid <= 1'b1;
                  fd_pc    <= pc;
                  fd_instr <= hold_instr;
                  fd_adel  <= hold_adel;
                  state    <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // The word being delivered is the delay slot; a redirect seen now aims the fetch after it.
         if (deliver) begin
            if (take_redirect) begin
               pc <= redirect_pc;
            end else begin
               pc            <= next_pc;
               pending_valid <= 1'b0;
            end
         end else if (take_redirect) begin
            pending_valid <= 1'b1;
            pending_pc    <= redirect_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: latency-programmable memory responder plus an
// in-order scoreboard of expected F/D deliveries, with per-scenario inline checks.
module tb_fetch_sequencer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } fd_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fd_stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        fd_valid;
   logic [31:0] fd_pc;
   logic [31:0] fd_instr;
   logic        fd_adel;

   fd_t sb_q[$];
   int  passed = 0;
   int  total = 0;
   bit  sb_open = 1'b0;
   int  mem_lat = 0;
   bit  force_ack = 1'b0;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .fd_stall      (fd_stall),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .fd_valid      (fd_valid),
      .fd_pc         (fd_pc),
      .fd_instr      (fd_instr),
      .fd_adel       (fd_adel)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
   endfunction

   function automatic fd_t exp_ok(input logic [31:0] a);
      fd_t e;
      e.pc = a; e.instr = mem_word(a); e.adel = 1'b0;
      return e;
   endfunction

   function automatic fd_t exp_bad(input logic [31:0] a);
      fd_t e;
      e.pc = a; e.instr = 32'h0; e.adel = 1'b1;
      return e;
   endfunction

   // Memory responder: acks after mem_lat wait cycles and checks the address holds while waiting.
   task automatic mem_loop();
      bit          waiting = 1'b0;
      logic [31:0] wait_addr = 32'h0;
      int          wait_cnt = 0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0; waiting = 1'b0;
         end else if (imem_req) begin
            if (waiting) begin
               total++;
               if (imem_addr !== wait_addr)
                  $display("FAIL addr_stable: got %h required %h", imem_addr, wait_addr);
               else passed++;
            end else begin
               waiting = 1'b1; wait_addr = imem_addr; wait_cnt = 0;
            end
            if (wait_cnt >= mem_lat) begin
               imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); waiting = 1'b0;
            end else begin
               imem_ack = 1'b0; imem_rdata = 32'hBAD0_BAD0; wait_cnt++;
            end
         end else begin
            imem_ack = 1'b0; waiting = 1'b0;
         end
      end
   endtask

   // Scoreboard: each new F/D content pops one expected entry; extras are flagged while open.
   task automatic mon_loop();
      fd_t got, prev, exp;
      bit  prev_valid = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         got = {fd_pc, fd_instr, fd_adel};
         if (fd_valid === 1'b1 && (!prev_valid || got !== prev)) begin
            if (sb_q.size() > 0) begin
               exp = sb_q.pop_front();
               total++;
               if (got !== exp)
                  $display("FAIL deliver: got pc=%h instr=%h adel=%b required pc=%h instr=%h adel=%b",
                           got.pc, got.instr, got.adel, exp.pc, exp.instr, exp.adel);
               else passed++;
            end else if (sb_open) begin
               total++;
               $display("FAIL unexpected_deliver: got pc=%h instr=%h required none", got.pc, got.instr);
            end
         end
         prev_valid = (fd_valid === 1'b1);
         prev = got;
      end
   endtask

   task automatic do_reset(input int lat);
      sb_open = 1'b0;
      sb_q.delete();
      reset = 1'b1;
      fd_stall = 1'b0;
      redirect_valid = 1'b0;
      mem_lat = lat;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sb_open = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 300 && sb_q.size() > 0; i++) @(posedge clk);
      #1;
      total++;
      if (sb_q.size() > 0) $display("FAIL drain_%s: got %0d pending required 0", name, sb_q.size());
      else passed++;
      sb_open = 1'b0;
      sb_q.delete();
   endtask

   task automatic find_fd(input logic [31:0] pc, output bit found);
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (fd_valid === 1'b1 && fd_pc === pc) begin
            found = 1'b1;
            return;
         end
      end
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc = target;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (fd_valid !== 1'b0) $display("FAIL reset_fd_valid: got %b required 0", fd_valid); else passed++;
      total++; if (fd_pc !== 32'h0) $display("FAIL reset_fd_pc: got %h required 0", fd_pc); else passed++;
      total++; if (fd_instr !== 32'h0) $display("FAIL reset_fd_instr: got %h required 0", fd_instr); else passed++;
      total++; if (fd_adel !== 1'b0) $display("FAIL reset_fd_adel: got %b required 0", fd_adel); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b required 0", imem_req); else passed++;
      reset = 1'b0;
      mem_lat = 0;
      sb_open = 1'b1;
      sb_q.push_back(exp_ok(32'h3000));
      total++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %b required 0", imem_req); else passed++;
      @(posedge clk); #1;
      total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b required 1", imem_req); else passed++;
      total++; if (imem_addr !== 32'h3000) $display("FAIL first_addr: got %h required 3000", imem_addr); else passed++;
      @(posedge clk); #1;
      total++; if (fd_valid !== 1'b1 || fd_pc !== 32'h3000)
         $display("FAIL first_deliver: got valid=%b pc=%h required valid=1 pc=3000", fd_valid, fd_pc);
      else passed++;
      wait_drain("reset");
   endtask

   task automatic test_zero_wait();
      bit found;
      do_reset(0);
      for (int k = 0; k < 4; k++) sb_q.push_back(exp_ok(32'h3000 + 32'(4 * k)));
      find_fd(32'h3000, found);
      total++; if (!found) $display("FAIL zw_start: got none required pc 3000"); else passed++;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         total++;
         if (fd_valid !== 1'b1 || fd_pc !== 32'h3000 + 32'(4 * k))
            $display("FAIL zw_stream: got valid=%b pc=%h required valid=1 pc=%h",
                     fd_valid, fd_pc, 32'h3000 + 32'(4 * k));
         else passed++;
      end
      wait_drain("zero_wait");
   endtask

   task automatic test_wait_states();
      bit found;
      do_reset(2);
      for (int k = 0; k < 3; k++) sb_q.push_back(exp_ok(32'h3000 + 32'(4 * k)));
      find_fd(32'h3000, found);
      total++; if (!found) $display("FAIL ws_start: got none required pc 3000"); else passed++;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         total++;
         if (fd_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h3004)
            $display("FAIL ws_bubble: got valid=%b req=%b addr=%h required valid=0 req=1 addr=3004",
                     fd_valid, imem_req, imem_addr);
         else passed++;
      end
      @(posedge clk); #1;
      total++;
      if (fd_valid !== 1'b1 || fd_pc !== 32'h3004)
         $display("FAIL ws_next: got valid=%b pc=%h required valid=1 pc=3004", fd_valid, fd_pc);
      else passed++;
      wait_drain("wait_states");
   endtask

   task automatic test_redirect_branch();
      bit found;
      do_reset(0);
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      sb_q.push_back(exp_ok(32'h3008)); sb_q.push_back(exp_ok(32'h3100));
      sb_q.push_back(exp_ok(32'h3104));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL br_find: got none required pc 3004"); else passed++;
      pulse_redirect(32'h3100);
      wait_drain("redirect_branch");
   endtask

   task automatic test_redirect_pending();
      bit found;
      do_reset(3);
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      sb_q.push_back(exp_ok(32'h3008)); sb_q.push_back(exp_ok(32'h3200));
      sb_q.push_back(exp_ok(32'h3204));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL pend_find: got none required pc 3004"); else passed++;
      pulse_redirect(32'h3200);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3008)
         $display("FAIL pend_slot_addr: got req=%b addr=%h required req=1 addr=3008", imem_req, imem_addr);
      else passed++;
      wait_drain("redirect_pending");
   endtask

   task automatic test_stall_hold();
      bit found;
      do_reset(0);
      for (int k = 0; k < 5; k++) sb_q.push_back(exp_ok(32'h3000 + 32'(4 * k)));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL st_find: got none required pc 3004"); else passed++;
      fd_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         total++;
         if (imem_req !== 1'b0 || fd_pc !== 32'h3004 || fd_valid !== 1'b1)
            $display("FAIL st_frozen: got req=%b valid=%b pc=%h required req=0 valid=1 pc=3004",
                     imem_req, fd_valid, fd_pc);
         else passed++;
      end
      fd_stall = 1'b0;
      @(posedge clk); #1;
      total++;
      if (fd_pc !== 32'h3008 || fd_instr !== mem_word(32'h3008))
         $display("FAIL st_release: got pc=%h instr=%h required pc=3008 instr=%h",
                  fd_pc, fd_instr, mem_word(32'h3008));
      else passed++;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h300C)
         $display("FAIL st_next_req: got req=%b addr=%h required req=1 addr=300c", imem_req, imem_addr);
      else passed++;
      wait_drain("stall_hold");
   endtask

   task automatic test_illegal_pc();
      bit found;
      do_reset(0);
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      sb_q.push_back(exp_ok(32'h3008)); sb_q.push_back(exp_bad(32'h3002));
      sb_q.push_back(exp_bad(32'h3006));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL mis_find: got none required pc 3004"); else passed++;
      pulse_redirect(32'h3002);
      total++; if (imem_req !== 1'b0) $display("FAIL mis_req: got %b required 0", imem_req); else passed++;
      @(posedge clk); #1;
      total++;
      if (fd_pc !== 32'h3002 || fd_adel !== 1'b1 || fd_instr !== 32'h0 || imem_req !== 1'b0)
         $display("FAIL mis_deliver: got pc=%h adel=%b instr=%h req=%b required pc=3002 adel=1 instr=0 req=0",
                  fd_pc, fd_adel, fd_instr, imem_req);
      else passed++;
      wait_drain("misaligned");

      do_reset(0);
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      sb_q.push_back(exp_ok(32'h3008)); sb_q.push_back(exp_bad(32'h2FFC));
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL low_find: got none required pc 3004"); else passed++;
      pulse_redirect(32'h2FFC);
      wait_drain("below_base");

      do_reset(0);
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      sb_q.push_back(exp_ok(32'h3008)); sb_q.push_back(exp_ok(32'h6FFC));
      sb_q.push_back(exp_bad(32'h7000)); sb_q.push_back(exp_bad(32'h7004));
      find_fd(32'h3004, found);
      total++; if (!found) $display("FAIL high_find: got none required pc 3004"); else passed++;
      pulse_redirect(32'h6FFC);
      wait_drain("top_boundary");
   endtask

   task automatic test_reset_mid_wait();
      do_reset(5);
      repeat (2) @(posedge clk);
      #1;
      total++; if (imem_req !== 1'b1) $display("FAIL mid_req: got %b required 1", imem_req); else passed++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      force_ack = 1'b1;
      mem_lat = 0;
      sb_q.push_back(exp_ok(32'h3000)); sb_q.push_back(exp_ok(32'h3004));
      total++; if (imem_req !== 1'b0) $display("FAIL mid_idle_req: got %b required 0", imem_req); else passed++;
      @(posedge clk); #1;
      force_ack = 1'b0;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h3000)
         $display("FAIL mid_restart: got req=%b addr=%h required req=1 addr=3000", imem_req, imem_addr);
      else passed++;
      wait_drain("reset_mid_wait");
   endtask

   initial begin
      fork
         mem_loop();
         mon_loop();
      join_none
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_redirect_branch();
      test_redirect_pending();
      test_stall_hold();
      test_illegal_pc();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller for the five-stage pipeline: owns the F-stage PC register, issues requests to instruction memory over a req/ack handshake, and loads the F/D pipeline register. It applies D-stage control-flow redirects (taken branch, j/jal, jr, already resolved into a target upstream) with MIPS delay-slot semantics, buffers a fetched word while the hazard unit stalls F/D, and raises an instruction-address error for misaligned or out-of-range PCs instead of issuing the access.

## Interface

- RESET_PC, 32'h0000_3000, PC loaded on reset
- IMEM_BASE, 32'h0000_3000, lowest legal instruction address
- IMEM_WORDS, 4096, number of legal instruction words from IMEM_BASE
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- fd_stall  input  1  hazard unit freeze of F and F/D register
- redirect_valid  input  1  D-stage instruction changes control flow
- redirect_pc  input  32  target for redirect_valid
- imem_req  output  1  fetch request
- imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  read data valid this cycle (may be same cycle as request)
- imem_rdata  input  32  instruction word, valid with imem_ack
- fd_valid  output  1  F/D register holds a real instruction
- fd_pc  output  32  PC of F/D instruction
- fd_instr  output  32  F/D instruction word
- fd_adel  output  1  F/D instruction raised instruction-address error

## Operation

- Registers: pc, state, hold_instr, pending_valid, pending_pc, F/D outputs.
- States: IDLE (only after reset), WAIT (request outstanding), HOLD (word captured, F/D stalled).
- Reset: state=IDLE, pc=RESET_PC, pending_valid=0, hold_instr=0, fd_valid=0, fd_pc=0, fd_instr=0, fd_adel=0, imem_req=0.
- IDLE: imem_req=0; imem_ack ignored; next state WAIT.
- WAIT, pc legal: imem_req=1, imem_addr=pc.
  - ack & !fd_stall: fd_pc<=pc, fd_instr<=imem_rdata, fd_valid<=1, fd_adel<=0; pc<=next; stay WAIT.
  - ack & fd_stall: hold_instr<=imem_rdata; F/D unchanged; -> HOLD.
  - !ack & !fd_stall: fd_valid<=0 (bubble), fd_pc/fd_instr unchanged.
  - !ack & fd_stall: F/D unchanged.
- WAIT, pc illegal (pc[1:0]!=0, pc<IMEM_BASE, or pc>=IMEM_BASE+4*IMEM_WORDS): imem_req=0; treated as an immediate ack with data 32'h0 and fd_adel<=1 on delivery.
- HOLD: imem_req=0; while fd_stall=1 nothing changes; when fd_stall=0: F/D <= {1, pc, hold_instr, adel flag}, pc<=next, -> WAIT.
- next = pending_valid ? pending_pc : pc+4 (mod 2^32); consuming pending clears pending_valid.
- Redirect sampled only when fd_stall=0 (D instruction advancing). Delay slot: the fetch outstanding or held at that time is the delay slot and is delivered unchanged; the redirect targets the fetch after it.
  - Sampled in a cycle that also delivers (ack or release from HOLD): pc<=redirect_pc directly, pending untouched.
  - Otherwise: pending_valid<=1, pending_pc<=redirect_pc; a later redirect before consumption overwrites.
- reset mid-fetch: outstanding request abandoned; any ack in the IDLE cycle discarded.

## Timing

- One request outstanding at most; zero-wait memory (ack same cycle as req) gives one instruction per cycle.
- Reset released at edge E0: cycle after E0 is IDLE; next cycle imem_req=1, imem_addr=RESET_PC; with zero-wait ack, fd_valid=1, fd_pc=RESET_PC after that edge.
- Fetch latency: fd_* update on the edge ending the ack cycle (or the fd_stall-low cycle in HOLD).
- imem_addr changes only on edges where a delivery occurs or on reset.
- Illegal PC: delivered one cycle after pc takes that value, no memory access.

## Test plan

- Zero-wait memory, no stalls/redirects -> fd_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, fd_valid=1 continuously from the second cycle after reset.
- Ack delayed 2 cycles per fetch -> imem_addr held stable, fd_valid=0 bubbles between deliveries, no duplicated or skipped PC.
- Redirect to 0x3100 while D holds 0x3004 (branch), zero-wait -> delivered PCs 0x3008 (delay slot), then 0x3100, 0x3104.
- Redirect to 0x3200 while delay-slot fetch waits 3 cycles for ack -> pending held; delivery order delay slot then 0x3200.
- fd_stall high 3 cycles across an ack of 0x3008 -> F/D frozen, state HOLD, imem_req=0; on release fd_instr equals captured word, next request 0x300C.
- Redirect to 0x3002 and separately to 0x2FFC -> imem_req stays 0, fd_adel=1, fd_instr=0, fd_pc equals bad PC; reset mid-wait returns to IDLE and restarts at 0x3000.
